// File: rtl/token_run_pkg.sv
// Shared types for the token run-length analyser: queued run entry and default sizes.
package token_run_pkg;

   localparam int RUN_W          = 8;
   localparam int RUN_FIFO_DEPTH = 4;

   typedef struct packed {
      logic             sat;
      logic [RUN_W-1:0] len;
   } run_entry_t;

endpackage

// File: rtl/token_run_fifo.sv
// token_run_fifo: synchronous FIFO of run entries; head valid 1 cycle after push.
// Backpressure: push is ignored when full unless a pop frees the slot in the same cycle.
module token_run_fifo
   import token_run_pkg::*;
#(
   parameter int  DEPTH   = RUN_FIFO_DEPTH,
   parameter type entry_t = run_entry_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  entry_t din,
   output logic   full,
   input  logic   pop,
   output logic   empty,
   output entry_t head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   entry_t      mem [DEPTH];
   logic        wr_en;
   logic        rd_en;

   // Extra MSB on each pointer distinguishes full from empty.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign head  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/token_run_length.sv
// token_run_length: measures runs of 1s on a, queues {len,sat}; out_valid 1 cycle after run end.
// out_ready backpressure; a run ending on a full FIFO without a pop is dropped (drop, TOKEN_RUN_DROP_CNT_EN adds drop_cnt).
module token_run_length
   import token_run_pkg::*;
#(
   parameter int W     = RUN_W,
   parameter int DEPTH = RUN_FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         a,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_len,
   output logic         out_sat,
   output logic         drop
`ifdef TOKEN_RUN_DROP_CNT_EN
   ,
   output logic [W-1:0] drop_cnt
`endif
);

   typedef struct packed {
      logic         sat;
      logic [W-1:0] len;
   } entry_t;

   localparam logic [W-1:0] LEN_MAX = '1;

   logic [W-1:0] cnt;
   logic         satf;
   logic         run_end;
   logic         pop;
   logic         discard;
   logic         full;
   logic         empty;
   entry_t       din;
   entry_t       head;

   assign run_end = !a && (cnt != '0);
   assign pop     = !empty && out_ready;
   assign discard = run_end && full && !pop;
   assign din     = '{sat: satf, len: cnt};

   token_run_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (run_end),
      .din   (din),
      .full  (full),
      .pop   (pop),
      .empty (empty),
      .head  (head)
   );

   // Counter sticks at LEN_MAX and flags the overrun instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         satf <= 1'b0;
      end else if (a) begin
         if (cnt == LEN_MAX) satf <= 1'b1;
         else                cnt  <= cnt + 1'b1;
      end else if (run_end) begin
         cnt  <= '0;
         satf <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          drop <= 1'b0;
      else if (discard) drop <= 1'b1;
   end

`ifdef TOKEN_RUN_DROP_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                drop_cnt <= '0;
      else if (discard && drop_cnt != LEN_MAX) drop_cnt <= drop_cnt + 1'b1;
   end
`endif

   assign out_valid = !empty;
   assign out_len   = empty ? '0 : head.len;
   assign out_sat   = !empty && head.sat;

endmodule
